// File: rtl/window3x3_gen.sv
// Streaming 3x3 window generator: two line memories, border padding and regenerated
// framing. Define WINDOW_PAD_REPLICATE_EN for edge-replicate padding (default: zero).
module window3x3_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic signed [DATA_WIDTH-1:0] data_i,
    input  logic                         data_valid_i,
    input  logic                         sop_i,
    input  logic                         eop_i,
    input  logic                         sof_i,
    input  logic                         eof_i,
    output logic signed [DATA_WIDTH-1:0] data_o [9],
    output logic                         data_valid_o,
    output logic                         sop_o,
    output logic                         eop_o,
    output logic                         sof_o,
    output logic                         eof_o,
    output logic                         err_o
);

`ifdef WINDOW_PAD_REPLICATE_EN
    localparam bit REPLICATE = 1'b1;
`else
    localparam bit REPLICATE = 1'b0;
`endif

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_RUN, S_EOL, S_FLUSH} state_t;

    state_t                  r_state;
    logic [CW-1:0]           r_col;
    logic [RW-1:0]           r_row;
    logic [CW-1:0]           r_fcnt;
    logic                    r_eol_last;
    logic                    r_err;

    logic signed [DATA_WIDTH-1:0] r_line0 [IMG_WIDTH];
    logic signed [DATA_WIDTH-1:0] r_line1 [IMG_WIDTH];
    logic signed [DATA_WIDTH-1:0] r_top_q, r_mid_q, r_pix_q;

    logic r_ev_emit, r_ev_load, r_ev_padcol, r_ev_toppad, r_ev_botpad;
    logic r_ev_sop, r_ev_eop, r_ev_sof, r_ev_eof;

    logic signed [DATA_WIDTH-1:0] r_left [3];
    logic signed [DATA_WIDTH-1:0] r_mid  [3];

    logic [CW-1:0] w_pos_col, w_col_inc, w_addr;
    logic [RW-1:0] w_pos_row;
    logic          w_row_end, w_bad, w_wr;
    logic signed [DATA_WIDTH-1:0] w_col   [3];
    logic signed [DATA_WIDTH-1:0] w_right [3];

    always_comb begin
        w_pos_col = (sof_i || sop_i) ? '0 : r_col;
        w_pos_row = sof_i ? '0 : r_row;
        w_row_end = eop_i || eof_i;
        w_bad     = (eop_i && (w_pos_col != COL_LAST)) ||
                    (eof_i && ((w_pos_row != ROW_LAST) || (w_pos_col != COL_LAST)));
        w_col_inc = (w_pos_col == COL_LAST) ? COL_LAST : w_pos_col + 1'b1;
        w_addr    = w_pos_col;
        w_wr      = 1'b0;
        case (r_state)
            S_IDLE:        w_wr = data_valid_i && sof_i;
            S_FILL, S_RUN: w_wr = data_valid_i;
            // last EOL slot preloads column 0 of the bottom row for the flush
            S_EOL:         w_addr = '0;
            S_FLUSH:       w_addr = (r_fcnt == COL_LAST) ? '0 : r_fcnt + 1'b1;
            default:       ;
        endcase
    end

    // Line memories shift row-wise: line0 takes the old line1 entry as line1 takes the new pixel.
    always_ff @(posedge clk) begin
        r_top_q <= r_line0[w_addr];
        r_mid_q <= r_line1[w_addr];
        r_pix_q <= data_i;
        if (w_wr) begin
            r_line0[w_addr] <= r_line1[w_addr];
            r_line1[w_addr] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_col       <= '0;
            r_row       <= '0;
            r_fcnt      <= '0;
            r_eol_last  <= 1'b0;
            r_err       <= 1'b0;
            r_ev_emit   <= 1'b0;
            r_ev_load   <= 1'b0;
            r_ev_padcol <= 1'b0;
            r_ev_toppad <= 1'b0;
            r_ev_botpad <= 1'b0;
            r_ev_sop    <= 1'b0;
            r_ev_eop    <= 1'b0;
            r_ev_sof    <= 1'b0;
            r_ev_eof    <= 1'b0;
        end else begin
            r_ev_emit   <= 1'b0;
            r_ev_load   <= 1'b0;
            r_ev_padcol <= 1'b0;
            r_ev_toppad <= 1'b0;
            r_ev_botpad <= 1'b0;
            r_ev_sop    <= 1'b0;
            r_ev_eop    <= 1'b0;
            r_ev_sof    <= 1'b0;
            r_ev_eof    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (data_valid_i && sof_i) begin
                        r_state <= S_FILL;
                        r_col   <= COL_ONE;
                        r_row   <= '0;
                    end
                end
                S_FILL: begin
                    if (data_valid_i) begin
                        if (sof_i) begin
                            r_col <= COL_ONE;
                            r_row <= '0;
                        end else begin
                            if (w_bad) r_err <= 1'b1;
                            if (w_row_end) begin
                                r_state <= S_RUN;
                                r_col   <= '0;
                                r_row   <= ROW_ONE;
                            end else begin
                                r_col <= w_col_inc;
                            end
                        end
                    end
                end
                S_RUN: begin
                    if (data_valid_i) begin
                        if (sof_i) begin
                            r_state <= S_FILL;
                            r_col   <= COL_ONE;
                            r_row   <= '0;
                        end else begin
                            r_ev_load   <= (w_pos_col == '0);
                            r_ev_emit   <= (w_pos_col != '0);
                            r_ev_toppad <= (w_pos_row == ROW_ONE);
                            r_ev_sop    <= (w_pos_col == COL_ONE);
                            r_ev_sof    <= (w_pos_col == COL_ONE) && (w_pos_row == ROW_ONE);
                            if (w_bad) r_err <= 1'b1;
                            if (w_row_end) begin
                                r_state    <= S_EOL;
                                r_col      <= '0;
                                r_eol_last <= eof_i || (w_pos_row == ROW_LAST);
                                r_row      <= (w_pos_row == ROW_LAST) ? ROW_LAST : w_pos_row + 1'b1;
                            end else begin
                                r_col <= w_col_inc;
                            end
                        end
                    end
                end
                S_EOL: begin
                    if (data_valid_i) r_err <= 1'b1;
                    r_ev_emit   <= 1'b1;
                    r_ev_padcol <= 1'b1;
                    r_ev_eop    <= 1'b1;
                    r_ev_load   <= r_eol_last;
                    r_ev_botpad <= 1'b1;
                    r_fcnt      <= '0;
                    r_state     <= r_eol_last ? S_FLUSH : S_RUN;
                end
                S_FLUSH: begin
                    if (data_valid_i) r_err <= 1'b1;
                    r_ev_emit   <= 1'b1;
                    r_ev_botpad <= 1'b1;
                    r_ev_padcol <= (r_fcnt == COL_LAST);
                    r_ev_sop    <= (r_fcnt == '0);
                    r_ev_eop    <= (r_fcnt == COL_LAST);
                    r_ev_eof    <= (r_fcnt == COL_LAST);
                    if (r_fcnt == COL_LAST) begin
                        r_state <= S_IDLE;
                        r_col   <= '0;
                        r_row   <= '0;
                    end else begin
                        r_fcnt <= r_fcnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_col[0] = r_ev_toppad ? (REPLICATE ? r_mid_q : '0) : r_top_q;
        w_col[1] = r_mid_q;
        w_col[2] = r_ev_botpad ? (REPLICATE ? r_mid_q : '0) : r_pix_q;
        for (int unsigned k = 0; k < 3; k++) begin
            w_right[k] = r_ev_padcol ? (REPLICATE ? r_mid[k] : '0) : w_col[k];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k < 9; k++) data_o[k] <= '0;
            for (int unsigned k = 0; k < 3; k++) begin
                r_left[k] <= '0;
                r_mid[k]  <= '0;
            end
            data_valid_o <= 1'b0;
            sop_o        <= 1'b0;
            eop_o        <= 1'b0;
            sof_o        <= 1'b0;
            eof_o        <= 1'b0;
        end else begin
            data_valid_o <= r_ev_emit;
            sop_o        <= r_ev_emit && r_ev_sop;
            eop_o        <= r_ev_emit && r_ev_eop;
            sof_o        <= r_ev_emit && r_ev_sof;
            eof_o        <= r_ev_emit && r_ev_eof;
            if (r_ev_emit) begin
                for (int unsigned ky = 0; ky < 3; ky++) begin
                    data_o[3*ky]     <= r_left[ky];
                    data_o[3*ky + 1] <= r_mid[ky];
                    data_o[3*ky + 2] <= w_right[ky];
                    r_left[ky]       <= r_mid[ky];
                    r_mid[ky]        <= w_right[ky];
                end
            end
            // column 0 of a row restarts the window; it wins over the shift of a coincident EOL emit
            if (r_ev_load) begin
                for (int unsigned ky = 0; ky < 3; ky++) begin
                    r_left[ky] <= REPLICATE ? w_col[ky] : '0;
                    r_mid[ky]  <= w_col[ky];
                end
            end
        end
    end

    assign err_o = r_err;

endmodule

// File: tb/tb_window3x3_gen.sv
// Scoreboard bench for window3x3_gen at W=4, H=3, pixel (r,c) = 16r+c+1.
// Expected windows are queued at their trigger slot and checked by an output monitor.
module tb_window3x3_gen;
    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 3;

    logic clk = 1'b0;
    logic reset;
    logic signed [DW-1:0] data_i;
    logic data_valid_i, sop_i, eop_i, sof_i, eof_i;
    logic signed [DW-1:0] data_o [9];
    logic data_valid_o, sop_o, eop_o, sof_o, eof_o, err_o;

    window3x3_gen #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .reset(reset), .data_i(data_i), .data_valid_i(data_valid_i),
        .sop_i(sop_i), .eop_i(eop_i), .sof_i(sof_i), .eof_i(eof_i),
        .data_o(data_o), .data_valid_o(data_valid_o), .sop_o(sop_o), .eop_o(eop_o),
        .sof_o(sof_o), .eof_o(eof_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [71:0] d;
        logic        sop, eop, sof, eof;
        logic [31:0] trig;
        logic [7:0]  r, c;
    } exp_t;

    exp_t q[$];
    int n_checks = 0;
    int n_errors = 0;
    int n_pop    = 0;
    exp_t        mon_e;
    logic [71:0] mon_act;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] w9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
        return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    function automatic int pix_at(input int r, input int c);
`ifdef WINDOW_PAD_REPLICATE_EN
        int rr = (r < 0) ? 0 : (r > H-1) ? H-1 : r;
        int cc = (c < 0) ? 0 : (c > W-1) ? W-1 : c;
        return 16*rr + cc + 1;
`else
        if (r < 0 || r > H-1 || c < 0 || c > W-1) return 0;
        return 16*r + c + 1;
`endif
    endfunction

    function automatic logic [71:0] exp_win(input int r, input int c);
        logic [71:0] m;
`ifdef WINDOW_PAD_REPLICATE_EN
        if (r == 0 && c == 0) return w9(1, 1, 2, 1, 1, 2, 17, 17, 18);
        if (r == 2 && c == 3) return w9(19, 20, 20, 35, 36, 36, 35, 36, 36);
`else
        if (r == 0 && c == 0) return w9(0, 0, 0, 0, 1, 2, 0, 17, 18);
        if (r == 1 && c == 1) return w9(1, 2, 3, 17, 18, 19, 33, 34, 35);
        if (r == 2 && c == 3) return w9(19, 20, 0, 35, 36, 0, 0, 0, 0);
`endif
        m = '0;
        for (int ky = 0; ky < 3; ky++)
            for (int kx = 0; kx < 3; kx++)
                m[(3*ky + kx)*8 +: 8] = 8'(pix_at(r - 1 + ky, c - 1 + kx));
        return m;
    endfunction

    task automatic push_win(input int r, input int c);
        exp_t e;
        e.d    = exp_win(r, c);
        e.sop  = (c == 0);
        e.eop  = (c == W-1);
        e.sof  = (r == 0 && c == 0);
        e.eof  = (r == H-1 && c == W-1);
        e.trig = 32'(cyc);
        e.r    = 8'(r);
        e.c    = 8'(c);
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (data_valid_o) begin
            if (q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_window: got data_valid_o=1 required no window pending");
            end else begin
                mon_e = q.pop_front();
                n_pop++;
                for (int j = 0; j < 9; j++) mon_act[j*8 +: 8] = data_o[j];
                check($sformatf("win(%0d,%0d).data", mon_e.r, mon_e.c), mon_act, mon_e.d);
                check($sformatf("win(%0d,%0d).framing", mon_e.r, mon_e.c),
                      {sop_o, eop_o, sof_o, eof_o}, {mon_e.sop, mon_e.eop, mon_e.sof, mon_e.eof});
                check($sformatf("win(%0d,%0d).latency", mon_e.r, mon_e.c),
                      72'(cyc - int'(mon_e.trig)), 72'(2));
            end
        end
    end

    task automatic drive(input logic v, input int p, input logic sp, ep, sf, ef);
        data_valid_i = v;
        data_i       = DW'(p);
        sop_i        = sp;
        eop_i        = ep;
        sof_i        = sf;
        eof_i        = ef;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        drive(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_all_zero(input string name);
        logic [71:0] a;
        for (int j = 0; j < 9; j++) a[j*8 +: 8] = data_o[j];
        check({name, ".data"}, a, '0);
        check({name, ".ctrl"}, {data_valid_o, sop_o, eop_o, sof_o, eof_o, err_o}, '0);
    endtask

    // ab_r/ab_c: stop before that pixel; viol_row: valid pixel in that row's EOL slot
    task automatic send_frame(input int ab_r, input int ab_c, input int viol_row, input bit rst_flush);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == ab_r && c == ab_c) return;
                if (r >= 1 && c >= 1) push_win(r - 1, c - 1);
                drive(1'b1, 16*r + c + 1, c == 0, c == W-1, r == 0 && c == 0, r == H-1 && c == W-1);
            end
            if (r < H-1) begin
                if (r >= 1) push_win(r - 1, W - 1);
                if (r == viol_row) drive(1'b1, 85, 1'b0, 1'b0, 1'b0, 1'b0);
                else               drive_idle();
            end
        end
        push_win(H - 2, W - 1);
        drive_idle();
        if (rst_flush) begin
            drive_idle();
            check("err_sticky", 72'(err_o), 72'(1));
            reset = 1'b1;
            drive_idle();
            check_all_zero("reset_in_flush");
            reset = 1'b0;
        end else begin
            for (int k = 0; k < W; k++) begin
                push_win(H - 1, k);
                drive_idle();
            end
        end
        drive_idle();
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (q.size() == 0) break;
            drive_idle();
        end
        repeat (3) drive_idle();
        check("drain_queue", 72'(q.size()), 72'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        reset = 1'b1;
        data_valid_i = 1'b0; data_i = '0;
        sop_i = 1'b0; eop_i = 1'b0; sof_i = 1'b0; eof_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_state");
        reset = 1'b0;
        repeat (2) drive_idle();

        // clean frame
        s = n_pop;
        send_frame(-1, -1, -1, 1'b0);
        drain();
        check("count_clean", 72'(n_pop - s), 72'(12));
        check("err_clean", 72'(err_o), 72'(0));
        for (int j = 0; j < 9; j++) mon_act[j*8 +: 8] = data_o[j];
        check("hold.data", mon_act, exp_win(H - 1, W - 1));
        check("hold.valid", 72'(data_valid_o), 72'(0));

        // sof at input (2,1) abandons the frame; restart runs to completion
        s = n_pop;
        send_frame(2, 1, -1, 1'b0);
        send_frame(-1, -1, -1, 1'b0);
        drain();
        check("count_restart", 72'(n_pop - s), 72'(16));
        check("err_restart", 72'(err_o), 72'(0));

        // valid pixel in the EOL slot after row 1 is dropped and flags err_o
        s = n_pop;
        send_frame(-1, -1, 1, 1'b0);
        drain();
        check("count_eolviol", 72'(n_pop - s), 72'(12));
        check("err_eolviol", 72'(err_o), 72'(1));

        // reset during flush discards the bottom row
        s = n_pop;
        send_frame(-1, -1, -1, 1'b1);
        drain();
        check("count_rstflush", 72'(n_pop - s), 72'(8));

        s = n_pop;
        send_frame(-1, -1, -1, 1'b0);
        drain();
        check("count_after_rst", 72'(n_pop - s), 72'(12));
        check("err_after_rst", 72'(err_o), 72'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
